minterm_extractor: RTL and testbench

Sequential truth-table extractor: sweeps every input combination of an N-input combinational or registered logic function and streams out the index of each minterm where the function is 1. It is the inverse of SOP generation: circuit in, minterm list out. It sits beside a generated logic function in self-check and regression harnesses, driving the function's inputs and feeding a minterm sink or scoreboard over a valid/ready stream.

---
 rtl/minterm_pkg.sv | 14 +
 rtl/minterm_extractor.sv | 123 ++++++++++++
 tb/tb_minterm_extractor.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm extractor.
package minterm_pkg;

  localparam int unsigned SettleCntW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StEval,
    StEmit,
    StFin
  } state_e;

endpackage

// File: rtl/minterm_extractor.sv
// Sweeps all 2^N_INPUTS input vectors of an external logic function and streams out, in
// ascending order, the index of every vector where the function evaluates to 1.
module minterm_extractor
  import minterm_pkg::*;
#(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [N_INPUTS-1:0] dut_in,
  input  logic                dut_out,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [N_INPUTS-1:0] m_index,
  output logic [N_INPUTS:0]   ones_count
);

  localparam logic [SettleCntW-1:0] SettleInit = SettleCntW'(SETTLE);

  state_e                state_q;
  state_e                load_state;
  logic [N_INPUTS-1:0]   idx_q;
  logic [N_INPUTS-1:0]   idx_inc;
  logic [SettleCntW-1:0] settle_q;
  logic                  busy_q;
  logic                  done_q;
  logic [N_INPUTS-1:0]   dut_in_q;
  logic                  m_valid_q;
  logic [N_INPUTS-1:0]   m_index_q;
  logic [N_INPUTS:0]     ones_q;
  logic                  last_idx;
  logic                  advance;

  always_comb begin
    load_state = StWait;
    if (SETTLE == 0) begin
      load_state = StEval;
    end
    last_idx = &idx_q;
    idx_inc  = idx_q + N_INPUTS'(1);
    // Move to the next index: either the function was 0, or the sink took the emitted index.
    advance  = ((state_q == StEval) && !dut_out) || ((state_q == StEmit) && m_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dut_in_q  <= '0;
      m_valid_q <= 1'b0;
      m_index_q <= '0;
      ones_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            idx_q    <= '0;
            dut_in_q <= '0;
            ones_q   <= '0;
            settle_q <= SettleInit;
            busy_q   <= 1'b1;
            state_q  <= load_state;
          end
        end
        StWait: begin
          settle_q <= settle_q - SettleCntW'(1);
          if (settle_q <= SettleCntW'(1)) begin
            state_q <= StEval;
          end
        end
        StEval: begin
          if (dut_out) begin
            m_index_q <= idx_q;
            m_valid_q <= 1'b1;
            ones_q    <= ones_q + (N_INPUTS + 1)'(1);
            state_q   <= StEmit;
          end
        end
        StEmit: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // The all-ones compare ends the sweep, so idx never needs to wrap.
      if (advance) begin
        if (last_idx) begin
          state_q <= StFin;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          idx_q    <= idx_inc;
          dut_in_q <= idx_inc;
          settle_q <= SettleInit;
          state_q  <= load_state;
        end
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dut_in     = dut_in_q;
  assign m_valid    = m_valid_q;
  assign m_index    = m_index_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_minterm_extractor.sv
// Directed, table-driven bench for minterm_extractor across three parameterisations.
module tb_minterm_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // N=8, SETTLE=1: selectable combinational function.
  logic       start8, busy8, done8, dut_out8, m_valid8, m_ready8;
  logic [7:0] dut_in8, m_index8;
  logic [8:0] ones8;
  int         fn8;

  // N=3, SETTLE=1: registered constant-1 function.
  logic       start3, busy3, done3, dut_out3, m_valid3, m_ready3;
  logic [2:0] dut_in3, m_index3;
  logic [3:0] ones3;

  // N=4, SETTLE=0: fixed SOP.
  logic       start4, busy4, done4, dut_out4, m_valid4, m_ready4;
  logic [3:0] dut_in4, m_index4;
  logic [4:0] ones4;

  int n_cmp = 0;
  int n_bad = 0;
  int got_q[$];
  int exp_q[$];

  function automatic bit f8(input int fn, input int idx);
    if (fn == 0) return 1'b0;
    if (fn == 1) return 1'b1;
    return idx[0];
  endfunction

  // f = x3 x2 + x1' x0  (x3 is the MSB)
  function automatic bit f4(input logic [3:0] x);
    return (x[3] & x[2]) | (~x[1] & x[0]);
  endfunction

  always_comb begin
    dut_out8 = 1'b0;
    if (fn8 == 1) dut_out8 = 1'b1;
    else if (fn8 == 2) dut_out8 = dut_in8[0];
  end

  always_ff @(posedge clk) dut_out3 <= 1'b1;

  assign dut_out4 = f4(dut_in4);

  minterm_extractor #(.N_INPUTS(8), .SETTLE(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8), .dut_in(dut_in8),
    .dut_out(dut_out8), .m_valid(m_valid8), .m_ready(m_ready8), .m_index(m_index8),
    .ones_count(ones8)
  );

  minterm_extractor #(.N_INPUTS(3), .SETTLE(1)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .dut_in(dut_in3),
    .dut_out(dut_out3), .m_valid(m_valid3), .m_ready(m_ready3), .m_index(m_index3),
    .ones_count(ones3)
  );

  minterm_extractor #(.N_INPUTS(4), .SETTLE(0)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4), .dut_in(dut_in4),
    .dut_out(dut_out4), .m_valid(m_valid4), .m_ready(m_ready4), .m_index(m_index4),
    .ones_count(ones4)
  );

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Compares got_q against exp_q: length, then position of first differing element (-1 = none).
  task automatic check_stream(input string name);
    int bad_pos;
    bad_pos = -1;
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (bad_pos < 0 && got_q[i] != exp_q[i]) bad_pos = i;
    end
    check({name, "_first_bad_pos"}, bad_pos, -1);
  endtask

  task automatic sweep8(input string name, input int fn, input int exp_ones, input int exp_done);
    int  cyc;
    int  done_cyc;
    int  dones;
    bit  both_hi;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 256; i++) if (f8(fn, i)) exp_q.push_back(i);
    @(negedge clk);
    fn8    = fn;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check({name, "_busy_after_start"}, busy8, 1);
    check({name, "_ones_cleared"}, ones8, 0);
    cyc      = 1;
    done_cyc = -1;
    dones    = 0;
    both_hi  = 1'b0;
    while (cyc < 2000 && done_cyc < 0) begin
      if (m_valid8 && m_ready8) got_q.push_back(int'(m_index8));
      if (busy8 && done8) both_hi = 1'b1;
      if (done8) begin
        done_cyc = cyc;
        dones++;
      end
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      if (done8) dones++;
      @(negedge clk);
    end
    check({name, "_done_cycle"}, done_cyc, exp_done);
    check({name, "_done_pulses"}, dones, 1);
    check({name, "_ones_count"}, ones8, exp_ones);
    check({name, "_busy_done_overlap"}, both_hi, 0);
    check_stream({name, "_stream"});
  endtask

  // Full N=3 sweep; with bp set, stalls the sink for 10 cycles while index 3 is offered.
  task automatic sweep3(input string name, input bit bp);
    int cyc;
    bit held;
    bit hold_ok;
    bit seen_done;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    m_ready3 = 1'b1;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3    = 1'b0;
    cyc       = 0;
    held      = 1'b0;
    hold_ok   = 1'b1;
    seen_done = 1'b0;
    while (cyc < 500 && !seen_done) begin
      if (bp && !held && m_valid3 && m_index3 == 3'd3) begin
        held     = 1'b1;
        m_ready3 = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (!(m_valid3 && m_index3 == 3'd3 && dut_in3 == 3'd3)) hold_ok = 1'b0;
        end
        m_ready3 = 1'b1;
      end
      if (m_valid3 && m_ready3) got_q.push_back(int'(m_index3));
      if (done3) seen_done = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_seen"}, seen_done, 1);
    check({name, "_ones_count"}, ones3, 8);
    if (bp) begin
      check({name, "_stall_reached"}, held, 1);
      check({name, "_stall_stable"}, hold_ok, 1);
    end
    check_stream({name, "_stream"});
  endtask

  typedef struct {
    string name;
    int    fn;
    int    exp_ones;
    int    exp_done;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   cyc;
    int   dones;
    int   ones_at_done;
    int   exp_ones4;
    bit   seen_done;

    tbl[0] = '{name: "const0", fn: 0, exp_ones: 0,   exp_done: 513};
    tbl[1] = '{name: "const1", fn: 1, exp_ones: 256, exp_done: 769};
    tbl[2] = '{name: "odd_a",  fn: 2, exp_ones: 128, exp_done: 641};
    tbl[3] = '{name: "odd_b",  fn: 2, exp_ones: 128, exp_done: 641};

    rst = 1'b1;
    fn8 = 0;
    start8 = 1'b0; start3 = 1'b0; start4 = 1'b0;
    m_ready8 = 1'b1; m_ready3 = 1'b1; m_ready4 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_dut_in", dut_in8, 0);
    check("rst_m_valid", m_valid8, 0);
    check("rst_m_index", m_index8, 0);
    check("rst_ones_count", ones8, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      sweep8(tbl[v].name, tbl[v].fn, tbl[v].exp_ones, tbl[v].exp_done);
    end

    sweep3("backpressure", 1'b1);

    // Reset while index 5 is being offered.
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 0;
    while (cyc < 200 && !(m_valid3 && m_index3 == 3'd5)) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached_idx5", m_valid3 && m_index3 == 3'd5, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_m_valid", m_valid3, 0);
    check("midrst_busy", busy3, 0);
    check("midrst_dut_in", dut_in3, 0);
    check("midrst_ones_count", ones3, 0);
    rst = 1'b0;
    sweep3("after_rst", 1'b0);

    // N=4, SETTLE=0, start held high throughout the sweep.
    got_q.delete();
    exp_q.delete();
    exp_ones4 = 0;
    for (int i = 0; i < 16; i++) begin
      if (f4(4'(i))) begin
        exp_q.push_back(i);
        exp_ones4++;
      end
    end
    @(negedge clk);
    start4 = 1'b1;
    cyc          = 0;
    dones        = 0;
    ones_at_done = -1;
    seen_done    = 1'b0;
    while (cyc < 300 && !seen_done) begin
      @(negedge clk);
      cyc++;
      if (m_valid4 && m_ready4) got_q.push_back(int'(m_index4));
      if (done4) begin
        seen_done    = 1'b1;
        dones++;
        ones_at_done = int'(ones4);
        start4       = 1'b0;
      end
    end
    start4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done4) dones++;
    end
    check("spam_start_done_pulses", dones, 1);
    check("spam_start_ones_count", ones_at_done, exp_ones4);
    check("spam_start_idle_after", busy4, 0);
    check_stream("spam_start_stream");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
